// File: rtl/cr16_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cr16_controller
// Description : Multicycle control FSM for the CR16 16-bit datapath. Decodes
//               the instruction register and drives every datapath control.
//               Optional macro MEM_WAIT_STATE_EN adds BRAM wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module cr16_controller #(
    parameter int SIZE = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] instr,
    input  logic [1:0]      flags1,
    input  logic [2:0]      flags2,
    output logic            ir_en,
    output logic            pcNexten,
    output logic            MemW1en,
    output logic            MemW2en,
    output logic            RFen,
    output logic            PSRen,
    output logic [1:0]      PCm,
    output logic [1:0]      A2m,
    output logic [1:0]      LUIm,
    output logic            Movm,
    output logic [1:0]      RWm,
    output logic [3:0]      AluOp,
    output logic [3:0]      state_dbg
);

`ifdef MEM_WAIT_STATE_EN
    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC    = 4'd2,
        ST_MEM     = 4'd3,
        ST_WB      = 4'd4,
        ST_FETCH_W = 4'd5,
        ST_LOAD_W  = 4'd6
    } state_t;
`else
    typedef enum logic [3:0] {
        ST_FETCH   = 4'd0,
        ST_DECODE  = 4'd1,
        ST_EXEC    = 4'd2,
        ST_MEM     = 4'd3,
        ST_WB      = 4'd4
    } state_t;
`endif

    localparam logic [3:0] c_alu_add   = 4'b0000;
    localparam logic [3:0] c_alu_sub   = 4'b0001;
    localparam logic [3:0] c_alu_cmp   = 4'b0010;
    localparam logic [3:0] c_alu_and   = 4'b0011;
    localparam logic [3:0] c_alu_or    = 4'b0100;
    localparam logic [3:0] c_alu_xor   = 4'b0101;
    localparam logic [3:0] c_alu_passb = 4'b0110;
    localparam logic [3:0] c_alu_lsh   = 4'b0111;

    state_t     r_state;
    logic [3:0] w_op;
    logic [3:0] w_ext;
    logic [3:0] w_cond;
    logic [3:0] w_acode;
    logic       w_c, w_f, w_l, w_z, w_n;
    logic       w_taken;
    logic       w_rtype;
    logic       w_arith;
    logic       w_is_load;
    logic       w_unused;

    assign w_op      = instr[15:12];
    assign w_cond    = instr[11:8];
    assign w_ext     = instr[7:4];
    assign w_unused  = ^instr[3:0];
    assign {w_c, w_f}      = flags1;
    assign {w_l, w_z, w_n} = flags2;

    // R-type arithmetic is keyed by ext; the immediate forms reuse the same code as op
    assign w_rtype   = (w_op == 4'b0000);
    assign w_acode   = w_rtype ? w_ext : w_op;
    assign w_arith   = w_acode inside {4'b0101, 4'b1001, 4'b1011, 4'b1101,
                                       4'b0001, 4'b0010, 4'b0011};
    assign w_is_load = (w_op == 4'b0100) && (w_ext == 4'b0000);

    always_comb begin
        case (w_cond)
            4'b0000: w_taken = w_z;
            4'b0001: w_taken = !w_z;
            4'b0010: w_taken = w_c;
            4'b0011: w_taken = !w_c;
            4'b0100: w_taken = w_l;
            4'b0101: w_taken = !w_l;
            4'b0110: w_taken = w_n;
            4'b0111: w_taken = !w_n;
            4'b1000: w_taken = w_f;
            4'b1001: w_taken = !w_f;
            4'b1010: w_taken = !w_l && !w_z;
            4'b1011: w_taken = w_l || w_z;
            4'b1100: w_taken = !w_n && !w_z;
            4'b1101: w_taken = w_n || w_z;
            4'b1110: w_taken = 1'b1;
            default: w_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= ST_FETCH;
        end else begin
            case (r_state)
`ifdef MEM_WAIT_STATE_EN
                ST_FETCH:   r_state <= ST_FETCH_W;
                ST_FETCH_W: r_state <= ST_DECODE;
                ST_MEM:     r_state <= ST_LOAD_W;
                ST_LOAD_W:  r_state <= ST_WB;
`else
                ST_FETCH:   r_state <= ST_DECODE;
                ST_MEM:     r_state <= ST_WB;
`endif
                ST_DECODE:  r_state <= ST_EXEC;
                ST_EXEC:    r_state <= w_is_load ? ST_MEM : ST_FETCH;
                ST_WB:      r_state <= ST_FETCH;
                default:    r_state <= ST_FETCH;
            endcase
        end
    end

    assign state_dbg = r_state;
    assign MemW1en   = 1'b0;

    always_comb begin
        ir_en    = 1'b0;
        pcNexten = 1'b0;
        MemW2en  = 1'b0;
        RFen     = 1'b0;
        PSRen    = 1'b0;
        PCm      = 2'b00;
        A2m      = 2'b00;
        LUIm     = 2'b00;
        Movm     = 1'b0;
        RWm      = 2'b00;
        AluOp    = c_alu_add;
        case (r_state)
            ST_DECODE: ir_en = 1'b1;
            ST_EXEC: begin
                if (w_arith) begin
                    pcNexten = 1'b1;
                    RWm      = 2'b10;
                    if (!w_rtype)
                        A2m = (w_acode inside {4'b0001, 4'b0010, 4'b0011}) ? 2'b11 : 2'b10;
                    case (w_acode)
                        4'b0101: AluOp = c_alu_add;
                        4'b1001: AluOp = c_alu_sub;
                        4'b1011: AluOp = c_alu_cmp;
                        4'b0001: AluOp = c_alu_and;
                        4'b0010: AluOp = c_alu_or;
                        4'b0011: AluOp = c_alu_xor;
                        default: AluOp = c_alu_passb;
                    endcase
                    Movm  = (w_acode != 4'b1101);
                    RFen  = (w_acode != 4'b1011);
                    PSRen = (w_acode != 4'b1101);
                end else begin
                    pcNexten = 1'b1;
                    case (w_op)
                        4'b1111: begin
                            RWm  = 2'b11;
                            RFen = 1'b1;
                        end
                        4'b1000: begin
                            if (w_ext == 4'b0100 || w_ext[3:1] == 3'b000) begin
                                AluOp = c_alu_lsh;
                                A2m   = (w_ext == 4'b0100) ? 2'b00 : 2'b01;
                                RFen  = 1'b1;
                                Movm  = 1'b1;
                                RWm   = 2'b10;
                            end
                        end
                        4'b0100: begin
                            case (w_ext)
                                4'b0000: pcNexten = 1'b0;
                                4'b0100: MemW2en  = 1'b1;
                                4'b1100: PCm      = w_taken ? 2'b01 : 2'b00;
                                4'b1000: begin
                                    RWm  = 2'b01;
                                    RFen = 1'b1;
                                    PCm  = 2'b01;
                                end
                                default: ;
                            endcase
                        end
                        4'b1100: begin
                            if (w_taken) begin
                                LUIm = 2'b01;
                                A2m  = 2'b10;
                                PCm  = 2'b10;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WB: begin
                RWm      = 2'b00;
                RFen     = 1'b1;
                pcNexten = 1'b1;
                PCm      = 2'b00;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cr16_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cr16_controller
// Description : Scoreboard bench for cr16_controller with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cr16_controller;

    typedef struct packed {
        logic [3:0] st;
        logic       ir_en, pcn, mw1, mw2, rfen, psren;
        logic [1:0] pcm, a2m, luim;
        logic       movm;
        logic [1:0] rwm;
        logic [3:0] aluop;
    } ctl_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic [1:0]  flags1;
    logic [2:0]  flags2;
    logic        ir_en, pcNexten, MemW1en, MemW2en, RFen, PSRen, Movm;
    logic [1:0]  PCm, A2m, LUIm, RWm;
    logic [3:0]  AluOp, state_dbg;

    int    total = 0;
    int    bad   = 0;
    ctl_t  exp_q[$];
    string tag_q[$];

    always #5 clk = ~clk;

    cr16_controller #(.SIZE(16)) dut (
        .clk(clk), .reset(reset), .instr(instr), .flags1(flags1), .flags2(flags2),
        .ir_en(ir_en), .pcNexten(pcNexten), .MemW1en(MemW1en), .MemW2en(MemW2en),
        .RFen(RFen), .PSRen(PSRen), .PCm(PCm), .A2m(A2m), .LUIm(LUIm), .Movm(Movm),
        .RWm(RWm), .AluOp(AluOp), .state_dbg(state_dbg)
    );

    function automatic bit cond_holds(logic [3:0] cc, logic [1:0] f1, logic [2:0] f2);
        bit C = f1[1], F = f1[0], L = f2[2], Z = f2[1], N = f2[0];
        case (cc)
            0: return Z;          1: return !Z;
            2: return C;          3: return !C;
            4: return L;          5: return !L;
            6: return N;          7: return !N;
            8: return F;          9: return !F;
            10: return !L && !Z;  11: return L || Z;
            12: return !N && !Z;  13: return N || Z;
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic string arith_name(logic [3:0] code);
        case (code)
            4'h5: return "ADD";  4'h9: return "SUB";  4'hB: return "CMP";
            4'hD: return "MOV";  4'h1: return "AND";  4'h2: return "OR";
            4'h3: return "XOR";
            default: return "";
        endcase
    endfunction

    function automatic ctl_t exec_model(logic [15:0] ins, logic [1:0] f1, logic [2:0] f2);
        ctl_t       e;
        logic [3:0] op, ext, cc;
        string      m;
        e   = '0;
        e.st = 4'd2;
        op  = ins[15:12];
        cc  = ins[11:8];
        ext = ins[7:4];
        e.pcn = 1'b1;
        m = arith_name(op == 4'h0 ? ext : op);
        if (m != "") begin
            e.rwm   = 2'b10;
            e.a2m   = (op == 4'h0) ? 2'd0 : ((m == "AND" || m == "OR" || m == "XOR") ? 2'd3 : 2'd2);
            e.aluop = (m == "ADD") ? 4'd0 : (m == "SUB") ? 4'd1 : (m == "CMP") ? 4'd2 :
                      (m == "AND") ? 4'd3 : (m == "OR")  ? 4'd4 : (m == "XOR") ? 4'd5 : 4'd6;
            e.movm  = (m != "MOV");
            e.rfen  = (m != "CMP");
            e.psren = (m != "MOV");
        end else if (op == 4'hF) begin
            e.rwm  = 2'b11;
            e.rfen = 1'b1;
        end else if (op == 4'h8 && (ext == 4'h4 || ext == 4'h0 || ext == 4'h1)) begin
            e.aluop = 4'd7;
            e.a2m   = (ext == 4'h4) ? 2'd0 : 2'd1;
            e.rfen  = 1'b1;
            e.movm  = 1'b1;
            e.rwm   = 2'b10;
        end else if (op == 4'h4 && ext == 4'h0) begin
            e.pcn = 1'b0;
        end else if (op == 4'h4 && ext == 4'h4) begin
            e.mw2 = 1'b1;
        end else if (op == 4'h4 && ext == 4'hC) begin
            e.pcm = cond_holds(cc, f1, f2) ? 2'd1 : 2'd0;
        end else if (op == 4'h4 && ext == 4'h8) begin
            e.rwm  = 2'b01;
            e.rfen = 1'b1;
            e.pcm  = 2'd1;
        end else if (op == 4'hC && cond_holds(cc, f1, f2)) begin
            e.luim = 2'd1;
            e.a2m  = 2'd2;
            e.pcm  = 2'd2;
        end
        return e;
    endfunction

    function automatic ctl_t expect_for(logic [3:0] st, logic [15:0] ins,
                                        logic [1:0] f1, logic [2:0] f2);
        ctl_t e;
        e = '0;
        e.st = st;
        case (st)
            4'd1: e.ir_en = 1'b1;
            4'd2: e = exec_model(ins, f1, f2);
            4'd4: begin
                e.rfen = 1'b1;
                e.pcn  = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Drives one instruction from its FETCH cycle; reset_at abandons it at that cycle index.
    task automatic run_instr(input logic [15:0] ins, input bit fixed, input logic [1:0] f1,
                             input logic [2:0] f2, input string tag, input int reset_at);
        logic [3:0] seq[$];
        seq.push_back(4'd0);
`ifdef MEM_WAIT_STATE_EN
        seq.push_back(4'd5);
`endif
        seq.push_back(4'd1);
        seq.push_back(4'd2);
        if (ins[15:12] == 4'h4 && ins[7:4] == 4'h0) begin
            seq.push_back(4'd3);
`ifdef MEM_WAIT_STATE_EN
            seq.push_back(4'd6);
`endif
            seq.push_back(4'd4);
        end
        for (int i = 0; i < seq.size(); i++) begin
            instr  = ins;
            flags1 = fixed ? f1 : 2'($urandom);
            flags2 = fixed ? f2 : 3'($urandom);
            if (i == reset_at) reset = 1'b0;
            exp_q.push_back(expect_for(seq[i], ins, flags1, flags2));
            tag_q.push_back($sformatf("%s@st%0d", tag, seq[i]));
            @(posedge clk);
            #1;
            if (i == reset_at) begin
                reset = 1'b1;
                return;
            end
        end
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] ins;
        logic [3:0]  ops[10];
        logic [3:0]  exts[8];
        ops  = '{4'h0, 4'h5, 4'h9, 4'hB, 4'hD, 4'h1, 4'hF, 4'h8, 4'h4, 4'hC};
        exts = '{4'h5, 4'h9, 4'hB, 4'hD, 4'h0, 4'h4, 4'h8, 4'hC};
        ins = 16'($urandom);
        if ($urandom_range(0, 3) != 0) ins[15:12] = ops[$urandom_range(0, 9)];
        if ($urandom_range(0, 3) != 0) ins[7:4]   = exts[$urandom_range(0, 7)];
        if (ins[15:12] == 4'h8 && $urandom_range(0, 1) == 1) ins[7:5] = 3'b000;
        return ins;
    endfunction

    initial begin : monitor
        ctl_t  act, exp;
        string tag;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                tag = tag_q.pop_front();
                act = '{state_dbg, ir_en, pcNexten, MemW1en, MemW2en, RFen, PSRen,
                        PCm, A2m, LUIm, Movm, RWm, AluOp};
                total++;
                if (act !== exp) begin
                    bad++;
                    $display("FAIL %s instr=%h got=%h want=%h (st,ir,pcn,mw1,mw2,rf,psr,pcm,a2m,luim,movm,rwm,alu)",
                             tag, instr, act, exp);
                end
            end
        end
    end

    initial begin : stimulus
        int waited;
        reset  = 1'b0;
        instr  = 16'h0000;
        flags1 = 2'b00;
        flags2 = 3'b000;
        @(posedge clk);
        #1;
        repeat (2) begin
            exp_q.push_back(expect_for(4'd0, 16'h0000, 2'b00, 3'b000));
            tag_q.push_back("reset_hold");
            @(posedge clk);
            #1;
        end
        reset = 1'b1;

        run_instr(16'h0152, 1'b1, 2'b00, 3'b000, "add_r",      -1);
        run_instr(16'hB305, 1'b1, 2'b00, 3'b000, "cmpi",       -1);
        run_instr(16'hC0FE, 1'b1, 2'b00, 3'b010, "beq_taken",  -1);
        run_instr(16'hC0FE, 1'b1, 2'b00, 3'b000, "beq_not",    -1);
        run_instr(16'h4102, 1'b1, 2'b00, 3'b000, "load",       -1);
        run_instr(16'h4E83, 1'b1, 2'b00, 3'b000, "jal",        -1);
        run_instr(16'h41C3, 1'b1, 2'b10, 3'b000, "jcs_taken",  -1);
        run_instr(16'h4FC3, 1'b1, 2'b11, 3'b111, "jnever",     -1);
        run_instr(16'h8012, 1'b1, 2'b00, 3'b000, "lshi",       -1);
        run_instr(16'h7123, 1'b1, 2'b00, 3'b000, "nop",        -1);
`ifdef MEM_WAIT_STATE_EN
        run_instr(16'h4102, 1'b1, 2'b00, 3'b000, "load_rst",    4);
`else
        run_instr(16'h4102, 1'b1, 2'b00, 3'b000, "load_rst",    3);
`endif
        run_instr(16'h0152, 1'b1, 2'b00, 3'b000, "after_rst",  -1);

        for (int n = 0; n < 300; n++)
            run_instr(rand_instr(), 1'b0, 2'b00, 3'b000, "rand", -1);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cr16_controller.md
Name: cr16_controller

Overview:
- Multicycle control FSM that drives every control input of the 16-bit datapath: enables, mux selects and ALU opcode.
- Decodes the instruction-register word and sequences fetch, decode, execute, memory and writeback.
- Uses PSR flags to resolve conditional branches and jumps.
- Acts as the initiator side of the datapath control interface and replaces the temporary switch-driven control inputs.

Parameters:
- SIZE, 16, datapath/instruction width (decode fields fixed for 16).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset. Sampled on the rising edge of clk; 0 = reset.
- instr  in  SIZE  instruction register contents.
- flags1  in  2  PSR group 1: [1]=C, [0]=F.
- flags2  in  3  PSR group 2: [2]=L, [1]=Z, [0]=N.
- ir_en  out  1  instruction register load enable.
- pcNexten  out  1  PC register load enable.
- MemW1en  out  1  BRAM port A write enable (tied 0 in this revision).
- MemW2en  out  1  BRAM port B write enable.
- RFen  out  1  register file write enable.
- PSRen  out  1  PSR load enable.
- PCm  out  2  PC mux: 00 PC+1, 01 RFread (Rtarget), 10 aluOut.
- A2m  out  2  ALU-B mux: 00 RFread2, 01 zext instr[3:0], 10 sext instr[7:0], 11 zext instr[7:0].
- LUIm  out  2  ALU-A mux: 00 RFread1, 01 PC.
- Movm  out  1  0 pass ALU-B operand, 1 aluOut.
- RWm  out  2  RF write mux: 00 MemRead2, 01 PC+1, 10 MovMux, 11 luiImmd.
- AluOp  out  4  0000 ADD, 0001 SUB, 0010 CMP, 0011 AND, 0100 OR, 0101 XOR, 0110 PASSB, 0111 LSH.
- state_dbg  out  4  current state encoding, for LEDs and the testbench.

Behaviour:
- Decode fields: op=instr[15:12], ext=instr[7:4], Rdest=instr[11:8], Rsrc=instr[3:0].
- Controls are Moore/Mealy combinational from (state, instr, flags). Unlisted outputs are 0; mux selects default to 00.
- States and encodings:
  - FETCH=0: PC drives BRAM port A. No enables asserted.
  - DECODE=1: ir_en=1. Next state is always EXEC.
  - EXEC=2: dispatch on op/ext, per the instruction rules below.
  - MEM=3: load access cycle. Next state WB.
  - WB=4: load writeback.
- Reset: when reset=0 at a clock edge, state=FETCH. This applies even mid-instruction; any pending write is abandoned. All enables are 0 the cycle after reset; state_dbg=0.
- R-type (op 0000), register to register, in EXEC:
  - ADD 0101, SUB 1001, AND 0001, OR 0010, XOR 0011: A2m=00, Movm=1, RWm=10, RFen=1, PSRen=1, pcNexten=1, PCm=00.
  - CMP 1011: as above but RFen=0, PSRen=1.
  - MOV 1101: AluOp=PASSB, Movm=0, RFen=1, PSRen=0.
- Immediate ops (op = ADD/SUB/CMP/MOV/AND/OR/XOR codes 0101/1001/1011/1101/0001/0010/0011), in EXEC:
  - Same as the R-type equivalent, but A2m=10 for ADDI/SUBI/CMPI/MOVI and A2m=11 for ANDI/ORI/XORI.
- LUI (op 1111): RWm=11, RFen=1, pcNexten=1.
- Shifts (op 1000):
  - ext 0100 (LSH): AluOp=LSH, A2m=00.
  - ext 000x (LSHI): AluOp=LSH, A2m=01; instr[4] is the direction, passed through the ALU.
  - Both: RFen=1, Movm=1, RWm=10, PSRen=0, pcNexten=1.
- LOAD (op 0100, ext 0000):
  - EXEC: no enables; next MEM.
  - MEM: no enables; next WB.
  - WB: RWm=00, RFen=1, pcNexten=1, PCm=00; next FETCH.
- STOR (op 0100, ext 0100): EXEC asserts MemW2en=1 and pcNexten=1 (PCm=00); next FETCH.
- Bcond (op 1100): cond=Rdest field.
  - Taken: LUIm=01, A2m=10, AluOp=ADD, PCm=10.
  - Not taken: PCm=00.
  - pcNexten=1 in both cases; PSRen=0.
- Jcond (op 0100, ext 1100): taken → PCm=01; otherwise PCm=00. pcNexten=1.
- JAL (op 0100, ext 1000): RWm=01, RFen=1, PCm=01, pcNexten=1. The link register write and the PC write occur on the same edge.
- Condition table:

| Code | Name | True when |
|---|---|---|
| 0000 | EQ | Z |
| 0001 | NE | !Z |
| 0010 | CS | C |
| 0011 | CC | !C |
| 0100 | HI | L |
| 0101 | LS | !L |
| 0110 | GT | N |
| 0111 | LE | !N |
| 1000 | FS | F |
| 1001 | FC | !F |
| 1010 | LO | !L&!Z |
| 1011 | HS | L\|Z |
| 1100 | LT | !N&!Z |
| 1101 | GE | N\|Z |
| 1110 | UC | always |
| 1111 | — | never |

- Undefined op/ext: treated as NOP; EXEC asserts only pcNexten=1 with PCm=00.
- Latency: ALU/branch/jump/store take 3 cycles; LOAD takes 5 cycles.
- Invariant: exactly one pcNexten pulse per instruction.
- Flags are sampled only in EXEC. A PSR update in EXEC affects only later instructions.

Optional Feature:
- Macro: MEM_WAIT_STATE_EN.
- Defined: adds FETCH_W=5 between FETCH and DECODE, and LOAD_W=6 between MEM and WB. Both wait states drive no enables. This supports BRAM with registered outputs: fetch latency +1, load latency +1 (4 and 7 cycles).
- Undefined: states 5 and 6 do not exist. Any unused encoding returns to FETCH on the next edge.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release → state_dbg=0; all enables 0 for the first cycle; ir_en=1 on cycle 2.
- ADD: instr=0x0152 (ADD R2→R1) → EXEC: RFen=1, PSRen=1, AluOp=0000, A2m=00, Movm=1, RWm=10, pcNexten=1; back in FETCH on cycle 4.
- CMP then BEQ:
  - CMPI instr=0xB305 → RFen=0, PSRen=1.
  - instr=0xC0FE with flags2=3'b010 → PCm=10, LUIm=01, A2m=10.
  - Same instr with flags2=3'b000 → PCm=00.
- LOAD: instr=0x4102 → state sequence 0,1,2,3,4; RFen=1 with RWm=00 only in WB; single pcNexten in WB.
- JAL: instr=0x4E83 → RFen=1, RWm=01, PCm=01, pcNexten=1 in one cycle.
- Reset mid-LOAD: assert reset=0 while in MEM → next state FETCH; no RFen pulse; no pcNexten.
